hbm_write_arbiter: RTL and testbench



---
 rtl/hbm_write_arbiter_pkg.sv | 25 ++
 rtl/hbm_write_arbiter_lane_fifo.sv | 62 ++++++
 rtl/hbm_write_arbiter.sv | 117 +++++++++++
 tb/tb_hbm_write_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hbm_write_arbiter_pkg.sv
// Shared definitions for the HBM write-back arbiter: lane slicing, FIFO occupancy width
// and the default almost-full margin.
`ifndef EDGE_PIPELINE_NUM
`define EDGE_PIPELINE_NUM 4
`endif
`ifndef VERTEX_AWIDTH
`define VERTEX_AWIDTH 32
`endif
`ifndef VERTEX_DWIDTH
`define VERTEX_DWIDTH 32
`endif

// Lane i of a flattened bus occupies bits [(i+1)*w-1 : i*w].
`define LANE_SLICE(vec, lane, w) vec[(lane)*(w) +: (w)]

package hbm_write_arbiter_pkg;

    localparam int AFULL_MARGIN_DEFAULT = 2;

    // One extra bit beyond the pointer width so that full and empty are distinct.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hbm_write_arbiter_lane_fifo.sv
// Per-lane synchronous FIFO with first-word fall-through output.
// A push into a full FIFO is still accepted when the same cycle pops.
module lane_fifo
    import hbm_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int CW = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/hbm_write_arbiter.sv
// Buffers per-lane vertex updates and round-robins them onto one valid/ready HBM
// write port, flagging dropped updates since the upstream cannot stall.
module hbm_write_arbiter
    import hbm_write_arbiter_pkg::*;
#(
    parameter int EDGE_PIPELINE_NUM = `EDGE_PIPELINE_NUM,
    parameter int VERTEX_AWIDTH     = `VERTEX_AWIDTH,
    parameter int VERTEX_DWIDTH     = `VERTEX_DWIDTH,
    parameter int FIFO_DEPTH        = 16,
    parameter int AFULL_MARGIN      = AFULL_MARGIN_DEFAULT
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [EDGE_PIPELINE_NUM*VERTEX_AWIDTH-1:0] in_addr,
    input  logic [EDGE_PIPELINE_NUM*VERTEX_DWIDTH-1:0] in_data,
    input  logic [EDGE_PIPELINE_NUM-1:0]           in_valid,
    output logic [VERTEX_AWIDTH-1:0]               out_addr,
    output logic [VERTEX_DWIDTH-1:0]               out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [EDGE_PIPELINE_NUM-1:0]           lane_almost_full,
    output logic [EDGE_PIPELINE_NUM-1:0]           lane_overflow,
    output logic                                   idle
);

    localparam int N  = EDGE_PIPELINE_NUM;
    localparam int AW = VERTEX_AWIDTH;
    localparam int DW = VERTEX_DWIDTH;
    localparam int CW = occ_width(FIFO_DEPTH);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [AW+DW-1:0] lane_dout  [N];
    logic [CW-1:0]    lane_count [N];
    logic [N-1:0]     lane_full;
    logic [N-1:0]     lane_empty;
    logic [N-1:0]     lane_pop;
    logic [N-1:0]     lane_drop;
    logic [N-1:0]     af_next;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    grant_idx;
    logic             grant_found;
    logic             load;

    assign load = !out_valid || out_ready;

    for (genvar i = 0; i < N; i++) begin : g_lane
        lane_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (AW + DW)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_valid[i]),
            .pop   (lane_pop[i]),
            .din   ({`LANE_SLICE(in_addr, i, AW), `LANE_SLICE(in_data, i, DW)}),
            .dout  (lane_dout[i]),
            .full  (lane_full[i]),
            .empty (lane_empty[i]),
            .count (lane_count[i])
        );
    end

    // Round-robin search: first non-empty lane at or after rr_ptr, wrapping modulo N.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!grant_found && !lane_empty[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        int occ_next;
        lane_pop  = '0;
        lane_drop = '0;
        af_next   = '0;
        occ_next  = 0;
        for (int i = 0; i < N; i++) begin
            lane_pop[i]  = load && grant_found && (grant_idx == PW'(i));
            lane_drop[i] = in_valid[i] && lane_full[i] && !lane_pop[i];
            occ_next     = int'(lane_count[i])
                         + ((in_valid[i] && !lane_drop[i]) ? 1 : 0)
                         - (lane_pop[i] ? 1 : 0);
            af_next[i]   = (occ_next >= FIFO_DEPTH - AFULL_MARGIN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid        <= 1'b0;
            out_addr         <= '0;
            out_data         <= '0;
            rr_ptr           <= '0;
            lane_almost_full <= '0;
            lane_overflow    <= '0;
            idle             <= 1'b1;
        end else begin
            if (load) begin
                out_valid <= grant_found;
                if (grant_found) begin
                    {out_addr, out_data} <= lane_dout[grant_idx];
                    rr_ptr               <= PW'((int'(grant_idx) + 1) % N);
                end
            end
            lane_overflow    <= lane_overflow | lane_drop;
            lane_almost_full <= af_next;
            idle             <= (&lane_empty) && !out_valid && !(|in_valid);
        end
    end

endmodule

// File: tb/tb_hbm_write_arbiter.sv
// Directed and randomized checks of hbm_write_arbiter against a queue-based
// transaction model of the lane FIFOs, round-robin grant and output register.
module tb_hbm_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int D  = 8;
    localparam int M  = 2;

    typedef logic [AW+DW-1:0] entry_t;

    logic            clk;
    logic            rst;
    logic [N*AW-1:0] in_addr;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [AW-1:0]   out_addr;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    lane_almost_full;
    logic [N-1:0]    lane_overflow;
    logic            idle;

    int checks   = 0;
    int failures = 0;

    entry_t       mq [N][$];
    logic         m_ov;
    entry_t       m_out;
    int           m_rr;
    logic [N-1:0] m_ovf;
    logic [N-1:0] m_af;
    logic         m_idle;

    hbm_write_arbiter #(
        .EDGE_PIPELINE_NUM (N),
        .VERTEX_AWIDTH     (AW),
        .VERTEX_DWIDTH     (DW),
        .FIFO_DEPTH        (D),
        .AFULL_MARGIN      (M)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_addr          (in_addr),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .out_addr         (out_addr),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .lane_almost_full (lane_almost_full),
        .lane_overflow    (lane_overflow),
        .idle             (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: output register first pops from the queues, then new
    // updates are appended, so a full lane that was just popped still has room.
    task automatic model_edge(input logic rst_v, input logic [N-1:0] vld,
                              input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                              input logic rdy);
        logic all_empty;
        logic found;
        logic next_idle;
        int   g;
        if (!rst_v) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_ov = 1'b0; m_out = '0; m_rr = 0; m_ovf = '0; m_af = '0; m_idle = 1'b1;
            return;
        end
        all_empty = 1'b1;
        for (int i = 0; i < N; i++) if (mq[i].size() != 0) all_empty = 1'b0;
        next_idle = all_empty && !m_ov && (vld == '0);
        if (!m_ov || rdy) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                g = (m_rr + k) % N;
                if (!found && mq[g].size() > 0) begin
                    found = 1'b1;
                    m_out = mq[g].pop_front();
                    m_rr  = (g + 1) % N;
                end
            end
            m_ov = found;
        end
        for (int i = 0; i < N; i++) begin
            if (vld[i]) begin
                if (mq[i].size() < D) mq[i].push_back({a[i*AW +: AW], d[i*DW +: DW]});
                else m_ovf[i] = 1'b1;
            end
            m_af[i] = (mq[i].size() >= D - M);
        end
        m_idle = next_idle;
    endtask

    task automatic check_output();
        check("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            check("out_addr", 64'(out_addr), 64'(m_out[AW+DW-1:DW]));
            check("out_data", 64'(out_data), 64'(m_out[DW-1:0]));
        end
        check("lane_almost_full", 64'(lane_almost_full), 64'(m_af));
        check("lane_overflow", 64'(lane_overflow), 64'(m_ovf));
        check("idle", 64'(idle), 64'(m_idle));
    endtask

    task automatic apply_stimulus(input logic rst_v, input logic [N-1:0] vld,
                                  input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                                  input logic rdy);
        rst       = rst_v;
        in_valid  = vld;
        in_addr   = a;
        in_data   = d;
        out_ready = rdy;
        @(posedge clk);
        model_edge(rst_v, vld, a, d, rdy);
        #1;
        check_output();
    endtask

    task automatic idle_steps(input int n, input logic rdy);
        for (int k = 0; k < n; k++) apply_stimulus(1'b1, '0, '0, '0, rdy);
    endtask

    function automatic logic [N*DW-1:0] rand_data();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    initial begin
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;

        rst = 1'b0; in_valid = '0; in_addr = '0; in_data = '0; out_ready = 1'b1;

        apply_stimulus(1'b0, '0, '0, '0, 1'b1);
        apply_stimulus(1'b0, '1, '1, '1, 1'b1);
        check("reset_out_addr", 64'(out_addr), 64'h0);
        check("reset_out_data", 64'(out_data), 64'h0);
        check("reset_idle", 64'(idle), 64'h1);

        $display("[TB] single update on lane 2");
        a = '0; d = '0;
        a[2*AW +: AW] = 16'h0010;
        d[2*DW +: DW] = 16'h0005;
        apply_stimulus(1'b1, 4'b0100, a, d, 1'b1);
        check("single_idle_low", 64'(idle), 64'h0);
        apply_stimulus(1'b1, '0, '0, '0, 1'b1);
        check("single_valid", 64'(out_valid), 64'h1);
        check("single_addr", 64'(out_addr), 64'h10);
        check("single_data", 64'(out_data), 64'h5);
        idle_steps(3, 1'b1);
        check("single_idle_back", 64'(idle), 64'h1);

        $display("[TB] all-lane bursts");
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'(i);
            apply_stimulus(1'b1, '1, a, rand_data(), 1'b1);
            idle_steps(N + 2, 1'b1);
        end
        a[0 +: AW] = 16'h0077;
        apply_stimulus(1'b1, 4'b0001, a, rand_data(), 1'b1);
        idle_steps(3, 1'b1);

        $display("[TB] back-pressure on lane 0");
        for (int k = 0; k < D + 3; k++) begin
            a = '0; a[0 +: AW] = AW'(16'h100 + k);
            apply_stimulus(1'b1, 4'b0001, a, rand_data(), 1'b0);
        end
        check("bp_overflow0", 64'(lane_overflow[0]), 64'h1);
        check("bp_held_addr", 64'(out_addr), 64'h100);
        idle_steps(D + 3, 1'b1);

        $display("[TB] full plus pop on lane 1");
        for (int k = 0; k < D + 1; k++) begin
            a = '0; a[AW +: AW] = AW'(16'h200 + k);
            apply_stimulus(1'b1, 4'b0010, a, rand_data(), 1'b0);
        end
        a = '0; a[AW +: AW] = 16'h02FF;
        apply_stimulus(1'b1, 4'b0010, a, rand_data(), 1'b1);
        check("fullpop_overflow1", 64'(lane_overflow[1]), 64'h0);
        idle_steps(D + 3, 1'b1);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'($urandom);
            apply_stimulus(1'b1, N'($urandom), a, rand_data(), ($urandom_range(0, 9) < 6));
        end
        idle_steps(N * D + 4, 1'b1);

        $display("[TB] mid-burst reset");
        for (int k = 0; k < D + 2; k++) begin
            for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'($urandom);
            apply_stimulus(1'b1, '1, a, rand_data(), 1'b0);
        end
        apply_stimulus(1'b0, '1, a, rand_data(), 1'b1);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_addr", 64'(out_addr), 64'h0);
        check("rst_overflow", 64'(lane_overflow), 64'h0);
        check("rst_almost_full", 64'(lane_almost_full), 64'h0);
        idle_steps(D + 4, 1'b1);
        check("post_rst_idle", 64'(idle), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
